// File: rtl/timer_reg_master.sv
`default_nettype none
// ============================================================================
//  Module   : timer_reg_master
//  Purpose  : Bus initiator for the timer register block. Turns a
//             valid/ready command stream into single-cycle register
//             accesses (module_en/wr/addr/wdata/rdata). It supports write,
//             read, poll-until-set and poll-until-clear, and returns one
//             response per command. Only one command is in flight at a time.
//
//  Ports    : clk, rst            - clock, async active-high reset
//             cmd_valid/cmd_ready - command handshake
//             cmd_op/addr/data    - 00 wr, 01 rd, 10 poll-set, 11 poll-clear;
//                                   data = write data or poll mask
//             rsp_valid/rsp_ready - response handshake
//             rsp_data/rsp_err    - read/poll data (0 for writes), timeout
//             busy                - FSM not idle
//             module_en/wr/addr/wdata/rdata - register bus
//
//  Config   : `define POLL_TIMEOUT_EN adds an 8-bit poll counter. A poll then
//             ends with rsp_err=1 after POLL_MAX failed reads. Without it,
//             polls run until the condition is met and rsp_err is tied to 0.
//
//  Revision : 1.0 - initial release
// ============================================================================
module timer_reg_master #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int POLL_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              module_en,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_gap    = 2'd2;
    localparam logic [1:0] c_st_resp   = 2'd3;

    localparam logic [1:0] c_op_wr   = 2'b00;
    localparam logic [1:0] c_op_pset = 2'b10;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_mask;
    logic              r_module_en;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;

    logic [1:0]        w_op_nxt;
    logic [DATA_W-1:0] w_mask_nxt;
    logic              w_module_en_nxt;
    logic              w_wr_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] w_rsp_data_nxt;
    logic              w_rsp_err_nxt;

    logic              w_is_poll;
    logic              w_poll_hit;
    logic              w_timeout;
    logic              w_access_done;

    // Poll condition, evaluated on the rdata returned during ACCESS.
    // A zero mask never hits for poll-set and always hits for poll-clear.
    always_comb begin
        w_is_poll  = r_op[1];
        if (r_op == c_op_pset) begin
            w_poll_hit = |(rdata & r_mask);
        end else begin
            w_poll_hit = ~|(rdata & r_mask);
        end
    end

`ifdef POLL_TIMEOUT_EN
    localparam logic [7:0] c_poll_max = 8'(POLL_MAX);

    logic [7:0] r_poll_cnt;
    logic [7:0] w_poll_cnt_nxt;
    logic       r_rsp_err;

    // Timeout fires on the read that would bring the failed count to POLL_MAX.
    assign w_timeout = ((r_poll_cnt + 8'd1) == c_poll_max);
`else
    assign w_timeout = 1'b0;

    logic w_unused_poll_max;
    assign w_unused_poll_max = (POLL_MAX == 0);
`endif

    // A write or read always finishes in one access; a poll finishes on a hit
    // or on timeout, otherwise it takes the GAP detour and re-reads.
    assign w_access_done = !w_is_poll || w_poll_hit || w_timeout;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (cmd_valid) begin
                    w_state_nxt = c_st_access;
                end
            end
            c_st_access: begin
                w_state_nxt = w_access_done ? c_st_resp : c_st_gap;
            end
            c_st_gap: begin
                w_state_nxt = c_st_access;
            end
            c_st_resp: begin
                if (rsp_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values for the output flops. Every bus and
    // response output comes straight from a register.
    // ------------------------------------------------------------------
    always_comb begin
        w_op_nxt        = r_op;
        w_mask_nxt      = r_mask;
        w_module_en_nxt = r_module_en;
        w_wr_nxt        = r_wr;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
`ifdef POLL_TIMEOUT_EN
        w_rsp_err_nxt   = r_rsp_err;
        w_poll_cnt_nxt  = r_poll_cnt;
`else
        w_rsp_err_nxt   = 1'b0;
`endif
        case (r_state)
            c_st_idle: begin
                if (cmd_valid) begin
                    w_op_nxt        = cmd_op;
                    w_mask_nxt      = cmd_data;
                    w_module_en_nxt = 1'b1;
                    w_wr_nxt        = (cmd_op == c_op_wr);
                    w_addr_nxt      = cmd_addr;
                    w_wdata_nxt     = (cmd_op == c_op_wr) ? cmd_data : '0;
                end
            end
            c_st_access: begin
                // The strobe lasts exactly this one cycle; addr is kept.
                w_module_en_nxt = 1'b0;
                w_wr_nxt        = 1'b0;
                w_wdata_nxt     = '0;
                w_rsp_data_nxt  = (r_op == c_op_wr) ? '0 : rdata;
                if (w_access_done) begin
                    w_rsp_valid_nxt = 1'b1;
                    // A hit takes precedence over a simultaneous timeout.
                    w_rsp_err_nxt   = w_is_poll && !w_poll_hit && w_timeout;
                end
`ifdef POLL_TIMEOUT_EN
                if (w_is_poll && !w_poll_hit) begin
                    w_poll_cnt_nxt = r_poll_cnt + 8'd1;
                end
`endif
            end
            c_st_gap: begin
                // Re-arm the strobe for the next poll read.
                w_module_en_nxt = 1'b1;
            end
            c_st_resp: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
`ifdef POLL_TIMEOUT_EN
                    w_poll_cnt_nxt  = 8'd0;
`endif
                end
            end
            default: begin
                w_module_en_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / command registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= 2'b00;
            r_mask      <= '0;
            r_module_en <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_op        <= w_op_nxt;
            r_mask      <= w_mask_nxt;
            r_module_en <= w_module_en_nxt;
            r_wr        <= w_wr_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
        end
    end

`ifdef POLL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_poll_cnt <= 8'd0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_poll_cnt <= w_poll_cnt_nxt;
            r_rsp_err  <= w_rsp_err_nxt;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    logic w_unused_rsp_err_nxt;
    assign w_unused_rsp_err_nxt = w_rsp_err_nxt;
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = (r_state == c_st_idle);
    assign busy      = (r_state != c_st_idle);
    assign module_en = r_module_en;
    assign wr        = r_wr;
    assign addr      = r_addr;
    assign wdata     = r_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_timer_reg_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_reg_master
//  Purpose  : Directed self-checking bench for timer_reg_master. It drives
//             commands, models the register slave's rdata and compares bus
//             activity and responses with hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timer_reg_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [5:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       module_en;
    logic       wr;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model: mode selects the rdata pattern, rel counts reads issued
    // since the current test began.
    int   mode    = 0;
    int   rd_cnt  = 0;
    int   rd_base = 0;
    int   rel;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (module_en && !wr) rd_cnt <= rd_cnt + 1;
    end

    always_comb begin
        rel   = rd_cnt - rd_base;
        rdata = 8'h00;
        case (mode)
            0: rdata = 8'h5C;
            1: rdata = 8'h01;
            2: rdata = (rel >= 2) ? 8'h01 : 8'h00;
            3: rdata = 8'h10 + 8'(rel);
            default: rdata = 8'h00;
        endcase
    end

    timer_reg_master #(
        .ADDR_W  (6),
        .DATA_W  (8),
        .POLL_MAX(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .module_en(module_en),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the ACCESS cycle.
    task automatic send(input logic [1:0] op, input logic [5:0] a, input logic [7:0] d);
        int n;
        n = 0;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
    endtask

    // Counts cycles before rsp_valid, strobe pulses and the strobe pattern.
    task automatic wait_rsp(output int cyc, output int pulses, output logic [15:0] pat);
        cyc    = 0;
        pulses = 0;
        pat    = 16'h0;
        while (!rsp_valid && cyc < 40) begin
            pat = {pat[14:0], module_en};
            pulses += int'(module_en);
            cyc++;
            @(negedge clk);
        end
        check("rsp_wait", {31'd0, rsp_valid}, 32'd1);
    endtask

    // With rsp_ready high, the handshake completes at the next edge.
    task automatic after_rsp();
        @(negedge clk);
        check("rsp_drop", {31'd0, rsp_valid}, 32'd0);
        check("idle_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    int          cyc;
    int          pulses;
    logic [15:0] pat;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 6'h00;
        cmd_data  = 8'h00;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_module_en", {31'd0, module_en}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data",  {24'd0, rsp_data},  32'h00);
        check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("rst_addr",      {26'd0, addr},      32'h00);
        check("rst_wdata",     {24'd0, wdata},     32'h00);
        rst = 1'b0;
        @(negedge clk);

        // Write 0x3C to 0x0A
        send(2'b00, 6'h0A, 8'h3C);
        check("wr_en",    {31'd0, module_en}, 32'd1);
        check("wr_wr",    {31'd0, wr},        32'd1);
        check("wr_addr",  {26'd0, addr},      32'h0A);
        check("wr_wdata", {24'd0, wdata},     32'h3C);
        check("wr_ready", {31'd0, cmd_ready}, 32'd0);
        wait_rsp(cyc, pulses, pat);
        check("wr_lat",    cyc,    32'd1);
        check("wr_pulses", pulses, 32'd1);
        check("wr_rdata",  {24'd0, rsp_data}, 32'h00);
        check("wr_err",    {31'd0, rsp_err},  32'd0);
        check("wr_en_off", {31'd0, module_en}, 32'd0);
        check("wr_wdata0", {24'd0, wdata},    32'h00);
        check("wr_addr_hold", {26'd0, addr},  32'h0A);
        after_rsp();

        // Read 0x04, slave returns 0x5C; command data must be ignored
        mode = 0;
        send(2'b01, 6'h04, 8'hAA);
        check("rd_en",    {31'd0, module_en}, 32'd1);
        check("rd_wr",    {31'd0, wr},        32'd0);
        check("rd_addr",  {26'd0, addr},      32'h04);
        check("rd_wdata", {24'd0, wdata},     32'h00);
        wait_rsp(cyc, pulses, pat);
        check("rd_lat",  cyc, 32'd1);
        check("rd_data", {24'd0, rsp_data}, 32'h5C);
        check("rd_err",  {31'd0, rsp_err},  32'd0);
        after_rsp();

        // Poll-set mask 0x01, bit 0 appears on the 3rd read
        mode    = 2;
        rd_base = rd_cnt;
        send(2'b10, 6'h04, 8'h01);
        cmd_op   = 2'b11;
        cmd_data = 8'hFE;
        wait_rsp(cyc, pulses, pat);
        check("pset_cycles",  cyc,    32'd5);
        check("pset_pulses",  pulses, 32'd3);
        check("pset_pattern", {16'd0, pat}, 32'h0015);
        check("pset_data",    {24'd0, rsp_data}, 32'h01);
        check("pset_err",     {31'd0, rsp_err},  32'd0);
        after_rsp();

        // Poll-clear mask 0x06 with rdata 0x01: hit on the first read
        mode = 1;
        send(2'b11, 6'h04, 8'h06);
        wait_rsp(cyc, pulses, pat);
        check("pclr_pulses", pulses, 32'd1);
        check("pclr_data",   {24'd0, rsp_data}, 32'h01);
        after_rsp();

        // Poll-clear with a zero mask succeeds immediately
        mode = 0;
        send(2'b11, 6'h07, 8'h00);
        wait_rsp(cyc, pulses, pat);
        check("pclr0_pulses", pulses, 32'd1);
        check("pclr0_data",   {24'd0, rsp_data}, 32'h5C);
        after_rsp();

`ifdef POLL_TIMEOUT_EN
        // Condition never met: 4 reads returning 0x10..0x13, then timeout
        mode    = 3;
        rd_base = rd_cnt;
        send(2'b10, 6'h04, 8'h80);
        wait_rsp(cyc, pulses, pat);
        check("tmo_pulses",  pulses, 32'd4);
        check("tmo_pattern", {16'd0, pat}, 32'h0055);
        check("tmo_err",     {31'd0, rsp_err},  32'd1);
        check("tmo_data",    {24'd0, rsp_data}, 32'h13);
        after_rsp();

        // Poll-set with a zero mask never hits; counter restarts from 0
        mode = 0;
        send(2'b10, 6'h04, 8'h00);
        wait_rsp(cyc, pulses, pat);
        check("tmo0_pulses", pulses, 32'd4);
        check("tmo0_err",    {31'd0, rsp_err},  32'd1);
        check("tmo0_data",   {24'd0, rsp_data}, 32'h5C);
        after_rsp();
`endif

        // Backpressure: response held for 5 cycles
        mode      = 0;
        rsp_ready = 1'b0;
        send(2'b01, 6'h04, 8'h00);
        wait_rsp(cyc, pulses, pat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_data",  {24'd0, rsp_data},  32'h5C);
            check("bp_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        after_rsp();

        // Asynchronous reset during ACCESS
        send(2'b00, 6'h0A, 8'h55);
        check("ar_en_before", {31'd0, module_en}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("ar_en",    {31'd0, module_en}, 32'd0);
        check("ar_busy",  {31'd0, busy},      32'd0);
        check("ar_ready", {31'd0, cmd_ready}, 32'd1);
        check("ar_addr",  {26'd0, addr},      32'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ar_no_rsp", {31'd0, rsp_valid}, 32'd0);
            check("ar_no_en",  {31'd0, module_en}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
